trivium_lite_sched: RTL and testbench

Multi-requester scheduler for the shared trivium-lite keystream generator. It arbitrates round-robin among NREQ requesters and locks one requester's session from seed to last byte. For each granted byte it seeds and steps the generator and assembles 8 keystream bits. It returns the requester's data byte XOR keystream on a single valid/ready output port.

---
 rtl/trivium_lite_sched.sv | 246 ++++++++++++++++++++++++
 tb/tb_trivium_lite_sched.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_lite_sched.sv
// ---------------------------------------------------------------------------
// trivium_lite_sched
//
// Round-robin scheduler in front of a shared trivium-lite keystream
// generator. A granted requester owns the generator from its seed load to
// the byte flagged last. For each byte the generator is stepped eight
// times, the bits are assembled MSB-first into a keystream byte, and the
// requester's byte XOR keystream is offered on a valid/ready output.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid[i]    requester i offers a byte (held until req_ready[i])
//   req_seed        8-bit session seed per requester, slice [8i+7:8i]
//   req_data        8-bit data byte per requester
//   req_last[i]     byte is the last of requester i's session
//   req_ready[i]    one-cycle pulse: byte (data, last) consumed
//   out_valid       result byte available
//   out_data        req_data ^ keystream byte
//   out_id          requester index of out_data
//   out_ready       downstream accepts out_data
//   gen_load        one-cycle pulse: generator loads gen_seed
//   gen_seed        seed for gen_load
//   gen_step        advance generator by one bit this cycle
//   gen_bit         current generator output bit
//   err_seed        one-cycle pulse: seed 8'h00 / 8'hFF rejected
//   busy            high in every state except IDLE
// ---------------------------------------------------------------------------
module trivium_lite_sched #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_seed,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [2:0]        out_id,
  input  logic              out_ready,
  output logic              gen_load,
  output logic [7:0]        gen_seed,
  output logic              gen_step,
  input  logic              gen_bit,
  output logic              err_seed,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    OUT  = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t     state, state_nxt;

  logic [2:0] rr_ptr;      // last requester served; search starts after it
  logic [2:0] owner;       // requester holding the current session
  logic [2:0] bit_cnt;     // keystream bits assembled in this RUN pass
  logic [7:0] ks;          // keystream shift register, first bit ends as MSB
  logic [7:0] data_lat;
  logic       last_lat;

  // -------------------------------------------------------------------------
  // Round-robin grant: first valid requester strictly above rr_ptr, then
  // wrap to the lowest valid index at or below rr_ptr.
  // -------------------------------------------------------------------------
  logic       grant_found;
  logic [2:0] grant_idx;
  logic [7:0] grant_seed;
  logic       grant_bad;

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (3'(i) > rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (3'(i) <= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    grant_seed = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 3'(i)) grant_seed = req_seed[8*i +: 8];
    end
  end

  // All-zero and all-one seeds would leave the generator in a degenerate
  // state, so they are rejected at grant time.
  assign grant_bad = (grant_seed == 8'h00) || (grant_seed == 8'hFF);

  // Owner's request lines, selected by index.
  logic       owner_valid;
  logic [7:0] owner_data;
  logic       owner_last;

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = 8'h00;
    owner_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 3'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[8*i +: 8];
        owner_last  = req_last[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: the reset branch covers every register here; there is no storage
  // array, so nothing is left uninitialised after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control outputs
  // -------------------------------------------------------------------------
  logic       ready_en;
  logic [2:0] ready_idx;

  always_comb begin
    state_nxt = state;
    ready_en  = 1'b0;
    ready_idx = owner;
    err_seed  = 1'b0;
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    out_valid = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_found && !rst) begin
          if (grant_bad) begin
            // Rejected seed is acknowledged in the grant cycle itself.
            ready_en  = 1'b1;
            ready_idx = grant_idx;
            err_seed  = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        gen_load  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        gen_step = 1'b1;
        if (bit_cnt == 3'd0) ready_en = 1'b1;
        if (bit_cnt == 3'd7) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_lat)         state_nxt = IDLE;
          else if (owner_valid) state_nxt = RUN;
          else                  state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (owner_valid) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ready_en && (ready_idx == 3'(i))) req_ready[i] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic [7:0] ks_nxt;
  assign ks_nxt = {ks[6:0], gen_bit};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= 3'(NREQ - 1);
      owner    <= 3'd0;
      bit_cnt  <= 3'd0;
      ks       <= 8'h00;
      data_lat <= 8'h00;
      last_lat <= 1'b0;
      out_data <= 8'h00;
      out_id   <= 3'd0;
      gen_seed <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            owner <= grant_idx;
            if (grant_bad) rr_ptr   <= grant_idx;
            else           gen_seed <= grant_seed;
          end
        end
        LOAD: begin
          bit_cnt <= 3'd0;
        end
        RUN: begin
          ks      <= ks_nxt;
          bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 for the next byte
          if (bit_cnt == 3'd0) begin
            data_lat <= owner_data;
            last_lat <= owner_last;
          end
          if (bit_cnt == 3'd7) begin
            out_data <= data_lat ^ ks_nxt;
            out_id   <= owner;
          end
        end
        OUT: begin
          if (out_ready && last_lat) rr_ptr <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_lite_sched.sv
// ---------------------------------------------------------------------------
// tb_trivium_lite_sched
//
// Directed testbench for trivium_lite_sched (NREQ=2). The generator is a
// stub: gen_bit is constant 1, or alternates 1,0,1,... starting after each
// gen_load. A negedge monitor logs grants, loads, steps and output
// handshakes; each test works from snapshots of those logs.
// ---------------------------------------------------------------------------
module tb_trivium_lite_sched;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_seed;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [2:0]        out_id;
  logic              out_ready;
  logic              gen_load;
  logic [7:0]        gen_seed;
  logic              gen_step;
  logic              gen_bit;
  logic              err_seed;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  trivium_lite_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_seed  (req_seed),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .gen_load  (gen_load),
    .gen_seed  (gen_seed),
    .gen_step  (gen_step),
    .gen_bit   (gen_bit),
    .err_seed  (err_seed),
    .busy      (busy)
  );

  // Generator stub
  logic alt_mode = 1'b0;
  logic alt_bit  = 1'b0;
  assign gen_bit = alt_mode ? alt_bit : 1'b1;
  always @(posedge clk) begin
    if (gen_load)      alt_bit <= 1'b1;
    else if (gen_step) alt_bit <= ~alt_bit;
  end

  // Monitor (only writer of these logs)
  int          n_load = 0, n_step = 0, n_err = 0, n_ov = 0, n_multi = 0;
  int          grants[$];
  logic [10:0] outs[$];      // {out_id, out_data} per output handshake

  always @(negedge clk) begin
    if (!rst) begin
      if (gen_load) n_load++;
      if (gen_step) n_step++;
      if (err_seed) n_err++;
      if (out_valid) n_ov++;
      if ($countones(req_ready) > 1) n_multi++;
      if (req_ready[0]) grants.push_back(0);
      if (req_ready[1]) grants.push_back(1);
      if (out_valid && out_ready) outs.push_back({out_id, out_data});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] seed,
                         input logic [7:0] data, input logic last);
    req_seed[8*i +: 8] = seed;
    req_data[8*i +: 8] = data;
    req_last[i]        = last;
    req_valid[i]       = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0; req_seed = '0; req_data = '0; req_last = '0;
    out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait for req_ready[i], then past the edge that consumes the byte.
  task automatic wait_ready(input int i, input string name);
    bit seen = 0;
    for (int n = 0; n < 200; n++) begin
      if (req_ready[i]) begin seen = 1; break; end
      tick();
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s: req_ready[%0d] got 0 required 1 within 200 cycles", name, i);
    end else begin
      tick();
    end
  endtask

  task automatic wait_outv(input string name);
    bit seen = 0;
    for (int n = 0; n < 200; n++) begin
      if (out_valid) begin seen = 1; break; end
      tick();
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s: out_valid got 0 required 1 within 200 cycles", name);
    end
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [27:0] obs;
    req_valid = 2'b01; req_seed = 16'h005A; req_data = 16'h003C; req_last = 2'b01;
    out_ready = 1'b1;
    rst = 1'b1;
    #2;
    obs = {req_ready, out_valid, out_data, out_id, gen_load, gen_seed,
           gen_step, err_seed, busy};
    tests_run++;
    if (obs !== 28'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_single_byte();
    int ld_c = -1, rd_c = -1, ov_c = -1, steps0;
    logic [7:0] seed_at_load = 8'h00, od = 8'h00;
    logic [2:0] oid = 3'd0;
    logic busy_after = 1'b1;
    do_reset();
    alt_mode = 1'b0;
    steps0 = n_step;
    set_req(0, 8'h5A, 8'h3C, 1'b1);          // cycle 0
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (gen_load && ld_c < 0) begin ld_c = k; seed_at_load = gen_seed; end
      if (req_ready[0] && rd_c < 0) rd_c = k;
      if (out_valid && ov_c < 0) begin ov_c = k; od = out_data; oid = out_id; end
      if (k == 3) req_valid[0] = 1'b0;
      if (k == 11) busy_after = busy;
    end
    tests_run++;
    if (ld_c != 1) begin tests_failed++; $display("FAIL single_load_cycle: got %0d required 1", ld_c); end
    tests_run++;
    if (seed_at_load !== 8'h5A) begin tests_failed++; $display("FAIL single_gen_seed: got %h required 5a", seed_at_load); end
    tests_run++;
    if (rd_c != 2) begin tests_failed++; $display("FAIL single_ready_cycle: got %0d required 2", rd_c); end
    tests_run++;
    if (ov_c != 10) begin tests_failed++; $display("FAIL single_outv_cycle: got %0d required 10", ov_c); end
    tests_run++;
    if (od !== 8'hC3) begin tests_failed++; $display("FAIL single_out_data: got %h required c3", od); end
    tests_run++;
    if (oid !== 3'd0) begin tests_failed++; $display("FAIL single_out_id: got %0d required 0", oid); end
    tests_run++;
    if (busy_after !== 1'b0) begin tests_failed++; $display("FAIL single_idle_after: busy got %b required 0", busy_after); end
    tests_run++;
    if (n_step - steps0 != 8) begin tests_failed++; $display("FAIL single_step_count: got %0d required 8", n_step - steps0); end
  endtask

  task automatic test_alternating();
    do_reset();
    alt_mode = 1'b1;
    set_req(0, 8'h5A, 8'h00, 1'b1);
    wait_ready(0, "alt_ready");
    req_valid[0] = 1'b0;
    wait_outv("alt_outv");
    tests_run++;
    if (out_data !== 8'hAA) begin tests_failed++; $display("FAIL alt_msb_first: got %h required aa", out_data); end
    tick();
    alt_mode = 1'b0;
  endtask

  task automatic test_fairness();
    int g0, o0, l0, m0;
    int exp_g[4] = '{0, 1, 0, 1};
    do_reset();
    g0 = grants.size(); o0 = outs.size(); l0 = n_load; m0 = n_multi;
    set_req(0, 8'h11, 8'h01, 1'b1);
    set_req(1, 8'h22, 8'h02, 1'b1);
    repeat (50) tick();
    req_valid = '0;
    repeat (15) tick();
    tests_run++;
    if (grants.size() - g0 != 5) begin tests_failed++; $display("FAIL fair_grant_count: got %0d required 5", grants.size() - g0); end
    for (int k = 0; k < 4; k++) begin
      if (g0 + k < grants.size()) begin
        tests_run++;
        if (grants[g0 + k] != exp_g[k]) begin
          tests_failed++;
          $display("FAIL fair_order[%0d]: got %0d required %0d", k, grants[g0 + k], exp_g[k]);
        end
      end
    end
    tests_run++;
    if (n_load - l0 != grants.size() - g0) begin
      tests_failed++;
      $display("FAIL fair_one_load_per_session: loads %0d required %0d", n_load - l0, grants.size() - g0);
    end
    tests_run++;
    if (n_multi != m0) begin tests_failed++; $display("FAIL fair_onehot_ready: multi-bit cycles got %0d required 0", n_multi - m0); end
    tests_run++;
    if (outs.size() - o0 < 2 || outs[o0] !== {3'd0, 8'hFE} || outs[o0 + 1] !== {3'd1, 8'hFD}) begin
      tests_failed++;
      $display("FAIL fair_out_data: got %0d outputs first %h required 0fe then 1fd",
               outs.size() - o0, (outs.size() > o0) ? outs[o0] : 11'h0);
    end
  endtask

  task automatic test_session_lock();
    int g0, o0, l0;
    logic [10:0] exp_o[3] = '{{3'd0, 8'h5E}, {3'd0, 8'h4D}, {3'd0, 8'h3C}};
    do_reset();
    g0 = grants.size(); o0 = outs.size(); l0 = n_load;
    set_req(0, 8'h33, 8'hA1, 1'b0);
    set_req(1, 8'h44, 8'h55, 1'b1);
    wait_ready(0, "lock_ready_b1");
    req_valid[0] = 1'b0;
    wait_outv("lock_outv_b1");
    repeat (5) tick();
    tests_run++;
    if (!(busy === 1'b1 && out_valid === 1'b0 && gen_step === 1'b0 && grants.size() - g0 == 1)) begin
      tests_failed++;
      $display("FAIL lock_wait_state: busy %b out_valid %b gen_step %b grants %0d required 1 0 0 1",
               busy, out_valid, gen_step, grants.size() - g0);
    end
    set_req(0, 8'h33, 8'hB2, 1'b0);
    wait_ready(0, "lock_ready_b2");
    set_req(0, 8'h33, 8'hC3, 1'b1);
    wait_ready(0, "lock_ready_b3");
    req_valid[0] = 1'b0;
    wait_ready(1, "lock_ready_req1");
    tests_run++;
    if (outs.size() - o0 != 3 || n_load - l0 != 2) begin
      tests_failed++;
      $display("FAIL lock_req1_after_last: outputs %0d loads %0d required 3 2", outs.size() - o0, n_load - l0);
    end
    tests_run++;
    if (grants.size() - g0 != 4 || grants[g0] != 0 || grants[g0+1] != 0 || grants[g0+2] != 0 || grants[g0+3] != 1) begin
      tests_failed++;
      $display("FAIL lock_grant_order: got %0d grants required 0,0,0,1", grants.size() - g0);
    end
    for (int k = 0; k < 3; k++) begin
      if (o0 + k < outs.size()) begin
        tests_run++;
        if (outs[o0 + k] !== exp_o[k]) begin
          tests_failed++;
          $display("FAIL lock_out[%0d]: got %h required %h", k, outs[o0 + k], exp_o[k]);
        end
      end
    end
    req_valid[1] = 1'b0;
    wait_outv("lock_outv_req1");
    tests_run++;
    if ({out_id, out_data} !== {3'd1, 8'hAA}) begin
      tests_failed++;
      $display("FAIL lock_req1_data: got %h required 1aa", {out_id, out_data});
    end
    tick();
  endtask

  task automatic test_illegal_seed();
    int l0, s0, v0, e0;
    do_reset();
    l0 = n_load; s0 = n_step; v0 = n_ov; e0 = n_err;
    set_req(0, 8'h00, 8'h12, 1'b1);
    set_req(1, 8'hFF, 8'h34, 1'b1);
    #1;
    tests_run++;
    if ({err_seed, req_ready, gen_load} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL illegal_00: err,ready,load got %b required 1010", {err_seed, req_ready, gen_load});
    end
    tick();
    req_valid[0] = 1'b0;
    #1;
    tests_run++;
    if ({err_seed, req_ready, gen_load} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL illegal_ff_next_cycle: err,ready,load got %b required 1100", {err_seed, req_ready, gen_load});
    end
    tick();
    req_valid[1] = 1'b0;
    repeat (12) tick();
    tests_run++;
    if (n_load != l0 || n_step != s0 || n_ov != v0 || n_err - e0 != 2 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_no_activity: loads %0d steps %0d outv %0d errs %0d busy %b required 0 0 0 2 0",
               n_load - l0, n_step - s0, n_ov - v0, n_err - e0, busy);
    end
  endtask

  task automatic test_backpressure_reset();
    int bp_bad = 0, g0, v0, l0;
    logic [27:0] obs;
    do_reset();
    out_ready = 1'b0;
    set_req(0, 8'h77, 8'h0F, 1'b0);
    wait_ready(0, "bp_ready");
    req_valid[0] = 1'b0;
    wait_outv("bp_outv");
    tests_run++;
    if ({out_id, out_data} !== {3'd0, 8'hF0}) begin
      tests_failed++;
      $display("FAIL bp_data: got %h required 0f0", {out_id, out_data});
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!(out_valid === 1'b1 && out_data === 8'hF0 && gen_step === 1'b0)) bp_bad++;
    end
    tests_run++;
    if (bp_bad != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: unstable cycles got %0d required 0", bp_bad);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (!(busy === 1'b1 && out_valid === 1'b0)) begin
      tests_failed++;
      $display("FAIL bp_wait_after_handshake: busy %b out_valid %b required 1 0", busy, out_valid);
    end
    set_req(0, 8'h77, 8'h11, 1'b0);
    wait_ready(0, "bp_ready_b2");
    req_valid[0] = 1'b0;
    tick(); tick();
    tests_run++;
    if (gen_step !== 1'b1) begin tests_failed++; $display("FAIL bp_mid_run: gen_step got %b required 1", gen_step); end
    rst = 1'b1;
    #1;
    obs = {req_ready, out_valid, out_data, out_id, gen_load, gen_seed,
           gen_step, err_seed, busy};
    tests_run++;
    if (obs !== 28'h0) begin
      tests_failed++;
      $display("FAIL midrun_reset_outputs: got %h required 0", obs);
    end
    tick(); tick();
    rst = 1'b0;
    g0 = grants.size(); v0 = n_ov; l0 = n_load;
    repeat (3) tick();
    tests_run++;
    if (grants.size() != g0 || n_ov != v0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_quiet: grants %0d outv %0d busy %b required 0 0 0",
               grants.size() - g0, n_ov - v0, busy);
    end
    set_req(1, 8'h99, 8'h66, 1'b1);
    wait_ready(1, "post_reset_ready");
    req_valid[1] = 1'b0;
    wait_outv("post_reset_outv");
    tests_run++;
    if ({out_id, out_data} !== {3'd1, 8'h99} || n_load - l0 != 1) begin
      tests_failed++;
      $display("FAIL post_reset_session: got %h loads %0d required 199 loads 1",
               {out_id, out_data}, n_load - l0);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_seed = '0; req_data = '0; req_last = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_byte();
    test_alternating();
    test_fairness();
    test_session_lock();
    test_illegal_seed();
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
